swap_reg_file: RTL and testbench
================================

SWAP_REG_FILE -- requirements
Module: swap_reg_file

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter ADDR_W, default 7, address width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter DATA_W, default 8, word width.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port w_en, input, 1, external write strobe.
REQ-007 The block SHALL have ports w_addr (input, ADDR_W) and w_data (input, DATA_W), carrying the external write address and data.
REQ-008 The block SHALL have ports r_addr0/r_addr1 (input, ADDR_W) and r_data0/r_data1 (output, DATA_W), forming two independent read ports.
REQ-009 The block SHALL have port swap_start, input, 1, request to swap two locations.
REQ-010 The block SHALL have ports swap_addr_a and swap_addr_b, input, ADDR_W each, giving the locations to swap.
REQ-011 The block SHALL have port swap_busy, output, 1, high while a swap is in progress.
REQ-012 The block SHALL have port swap_done, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port w_drop, output, 1, one-cycle pulse when an external write is discarded.

Function
REQ-014 Reads SHALL be combinational: r_dataN = mem[r_addrN] at all times, including intermediate swap states.
REQ-015 In IDLE, w_en=1 SHALL write w_data to mem[w_addr] at the clock edge.
REQ-016 The FSM SHALL have states IDLE, LOAD, WR_A, WR_B and DONE.
REQ-017 In IDLE, swap_start=1 SHALL capture swap_addr_a and swap_addr_b into internal registers and move the FSM to LOAD.
REQ-018 In LOAD, the block SHALL latch tmp_a<=mem[a] and tmp_b<=mem[b], then go to WR_A.
REQ-019 In WR_A, the block SHALL write mem[a]<=tmp_b, then go to WR_B.
REQ-020 In WR_B, the block SHALL write mem[b]<=tmp_a, then go to DONE.
REQ-021 In DONE, swap_done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-022 swap_busy SHALL be 1 exactly in LOAD, WR_A and WR_B (three cycles), and 0 in IDLE and DONE.
REQ-023 swap_start sampled in DONE SHALL be accepted as in IDLE (back-to-back swaps, four-cycle period).
REQ-024 swap_start while busy SHALL be ignored, with no queueing.
REQ-025 w_en while busy SHALL be discarded, with w_drop=1 in that same cycle.
REQ-026 w_en in DONE SHALL be accepted normally.
REQ-027 If w_en and swap_start are both 1 in IDLE/DONE, the write SHALL commit at that edge, and LOAD SHALL observe the written value.
REQ-028 If swap_addr_a == swap_addr_b, the full sequence SHALL still run (3 busy cycles plus done), and the contents SHALL be unchanged.
REQ-029 Swap addresses SHALL be used only as captured at acceptance; later changes to the inputs SHALL have no effect.
REQ-030 Address arithmetic SHALL be unsigned, full ADDR_W range, with no out-of-range case.

Reset
REQ-031 When rst=1 at a clock edge, every memory word, tmp_a, tmp_b and the captured addresses SHALL be cleared to 0.
REQ-032 When rst=1 at a clock edge, the FSM SHALL go to IDLE, and swap_busy, swap_done and w_drop SHALL be 0.
REQ-033 rst SHALL override any in-progress swap or write in the same cycle, leaving no partial state after reset.
REQ-034 After reset, both read ports SHALL return 0 for every address.

Structure
REQ-035 Package swap_rf_pkg SHALL hold the FSM state encoding (IDLE, LOAD, WR_A, WR_B, DONE) and the parameter defaults.
REQ-036 The control FSM SHALL be sub-module swap_ctrl, exposing busy, done, the load/write-select strobes and the captured addresses.
REQ-037 The storage array and its write mux SHALL stay in swap_reg_file.

Verification (ADDR_W=7, DATA_W=8)
REQ-038 Reset then read sweep: assert rst for 1 cycle, read all 128 addresses on both ports -> all 0x00; swap_busy=0, swap_done=0.
REQ-039 Basic swap: write mem[3]=0xA5 and mem[100]=0x3C, pulse swap_start(a=3, b=100) -> busy for 3 cycles, done pulse on 4th, mem[3]=0x3C, mem[100]=0xA5.
REQ-040 Dropped write: during a swap busy cycle, apply w_en with addr 7 / data 0xFF -> w_drop=1 that cycle, mem[7] unchanged.
REQ-041 Same-cycle write and start: in IDLE, w_en(addr 3, data 0x11) with swap_start(3, 4) where mem[4]=0x22 -> mem[3]=0x22, mem[4]=0x11.
REQ-042 Degenerate and back-to-back: swap(5,5) with mem[5]=0x77 -> unchanged with done; start swap(1,2) in the DONE cycle -> accepted, done 4 cycles later.
REQ-043 Reset mid-swap: assert rst in the WR_A cycle -> next cycle FSM IDLE, busy=0, done never pulses, all memory 0x00.

Source files
------------

// File: rtl/swap_rf_pkg.sv
// ---------------------------------------------------------------------------
// swap_rf_pkg
// Shared definitions for the swap register file: parameter defaults and the
// encoding of the swap control FSM states.
// ---------------------------------------------------------------------------
package swap_rf_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WR_A = 3'd2,
    ST_WR_B = 3'd3,
    ST_DONE = 3'd4
  } swap_state_t;

endpackage

// File: rtl/swap_ctrl.sv
// ---------------------------------------------------------------------------
// swap_ctrl
// Control FSM for swapping two register-file locations.
//   IDLE -> LOAD -> WR_A -> WR_B -> DONE -> (IDLE | LOAD)
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   swap_start        : swap request, honoured in IDLE and DONE only
//   swap_addr_a/_b    : locations to swap, captured on acceptance
//   busy              : high in LOAD, WR_A, WR_B
//   done              : one-cycle pulse in DONE
//   accept            : IDLE or DONE, external writes/starts may be taken
//   load_en           : LOAD state, latch both words into temporaries
//   wr_a_en / wr_b_en : WR_A / WR_B states, write back the swapped words
//   addr_a / addr_b   : captured swap addresses
// ---------------------------------------------------------------------------
module swap_ctrl
  import swap_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swap_start,
  input  logic [ADDR_W-1:0] swap_addr_a,
  input  logic [ADDR_W-1:0] swap_addr_b,
  output logic              busy,
  output logic              done,
  output logic              accept,
  output logic              load_en,
  output logic              wr_a_en,
  output logic              wr_b_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b
);

  swap_state_t       r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
    end else begin
      case (r_state)
        // DONE behaves like IDLE for new requests, giving a 4-cycle swap period.
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (swap_start) begin
            r_state  <= ST_LOAD;
            r_busy   <= 1'b1;
            r_addr_a <= swap_addr_a;
            r_addr_b <= swap_addr_b;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_LOAD: r_state <= ST_WR_A;
        ST_WR_A: r_state <= ST_WR_B;
        ST_WR_B: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign accept  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign load_en = (r_state == ST_LOAD);
  assign wr_a_en = (r_state == ST_WR_A);
  assign wr_b_en = (r_state == ST_WR_B);
  assign addr_a  = r_addr_a;
  assign addr_b  = r_addr_b;

endmodule

// File: rtl/swap_reg_file.sv
// ---------------------------------------------------------------------------
// swap_reg_file
// 2**ADDR_W x DATA_W register file with one external write port, two
// combinational read ports and a hardware swap of two locations.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset (clears all)
//   w_en, w_addr, w_data  : external write, taken in IDLE/DONE, dropped when busy
//   r_addr0/1, r_data0/1  : asynchronous read ports
//   swap_start            : request a swap of swap_addr_a and swap_addr_b
//   swap_busy             : swap in progress
//   swap_done             : one-cycle completion pulse
//   w_drop                : external write discarded this cycle
// ---------------------------------------------------------------------------
module swap_reg_file
  import swap_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] r_addr0,
  input  logic [ADDR_W-1:0] r_addr1,
  output logic [DATA_W-1:0] r_data0,
  output logic [DATA_W-1:0] r_data1,
  input  logic              swap_start,
  input  logic [ADDR_W-1:0] swap_addr_a,
  input  logic [ADDR_W-1:0] swap_addr_b,
  output logic              swap_busy,
  output logic              swap_done,
  output logic              w_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_tmp_a;
  logic [DATA_W-1:0] r_tmp_b;

  logic              w_busy;
  logic              w_done;
  logic              w_accept;
  logic              w_load;
  logic              w_wr_a;
  logic              w_wr_b;
  logic [ADDR_W-1:0] w_cap_a;
  logic [ADDR_W-1:0] w_cap_b;

  swap_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .swap_start  (swap_start),
    .swap_addr_a (swap_addr_a),
    .swap_addr_b (swap_addr_b),
    .busy        (w_busy),
    .done        (w_done),
    .accept      (w_accept),
    .load_en     (w_load),
    .wr_a_en     (w_wr_a),
    .wr_b_en     (w_wr_b),
    .addr_a      (w_cap_a),
    .addr_b      (w_cap_b)
  );

  // The FSM states are mutually exclusive, so at most one of the writes
  // below fires per cycle. An external write taken together with a start
  // lands before LOAD reads the array, so the swap sees the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_tmp_a <= '0;
      r_tmp_b <= '0;
    end else begin
      if (w_accept && w_en) begin
        r_mem[w_addr] <= w_data;
      end
      if (w_load) begin
        r_tmp_a <= r_mem[w_cap_a];
        r_tmp_b <= r_mem[w_cap_b];
      end
      if (w_wr_a) begin
        r_mem[w_cap_a] <= r_tmp_b;
      end
      if (w_wr_b) begin
        r_mem[w_cap_b] <= r_tmp_a;
      end
    end
  end

  assign r_data0   = r_mem[r_addr0];
  assign r_data1   = r_mem[r_addr1];
  assign swap_busy = w_busy;
  assign swap_done = w_done;
  // Reset wins over a pending drop so w_drop never pulses in a reset cycle.
  assign w_drop    = w_en & w_busy & ~rst;

endmodule

// File: tb/tb_swap_reg_file.sv
// ---------------------------------------------------------------------------
// tb_swap_reg_file
// Directed scenarios plus randomized traffic against a behavioural model of
// the swap register file (array + "cycles since swap accepted" counter).
// ---------------------------------------------------------------------------
module tb_swap_reg_file;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] r_addr0;
  logic [AW-1:0] r_addr1;
  logic [DW-1:0] r_data0;
  logic [DW-1:0] r_data1;
  logic          swap_start;
  logic [AW-1:0] swap_addr_a;
  logic [AW-1:0] swap_addr_b;
  logic          swap_busy;
  logic          swap_done;
  logic          w_drop;

  always #5 clk = ~clk;

  swap_reg_file #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_en        (w_en),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .r_addr0     (r_addr0),
    .r_addr1     (r_addr1),
    .r_data0     (r_data0),
    .r_data1     (r_data1),
    .swap_start  (swap_start),
    .swap_addr_a (swap_addr_a),
    .swap_addr_b (swap_addr_b),
    .swap_busy   (swap_busy),
    .swap_done   (swap_done),
    .w_drop      (w_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // Reference model: plain array plus the number of edges since a swap was
  // accepted (0 = idle, 1..3 = busy, 4 = done cycle). The two words being
  // swapped are snapshotted at acceptance, since nothing may write them after.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_age = 0;
  logic [AW-1:0] m_a, m_b;
  logic [DW-1:0] m_va, m_vb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_age >= 1) && (m_age <= 3);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_age = 0;
        m_a   = '0;
        m_b   = '0;
      end else if (m_busy()) begin
        if (m_age == 2) m_mem[m_a] = m_vb;
        if (m_age == 3) m_mem[m_b] = m_va;
        m_age++;
      end else begin
        if (w_en) m_mem[w_addr] = w_data;
        if (swap_start) begin
          m_a   = swap_addr_a;
          m_b   = swap_addr_b;
          m_va  = m_mem[swap_addr_a];
          m_vb  = m_mem[swap_addr_b];
          m_age = 1;
        end else begin
          m_age = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy",    32'(swap_busy), 32'(m_busy()));
        chk("done",    32'(swap_done), 32'(m_age == 4));
        chk("w_drop",  32'(w_drop),    32'(w_en && !rst && m_busy()));
        chk("r_data0", 32'(r_data0),   32'(m_mem[r_addr0]));
        chk("r_data1", 32'(r_data1),   32'(m_mem[r_addr1]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w_en   = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_en   = 1'b0;
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      r_addr0 = AW'(i);
      r_addr1 = AW'(DEPTH - 1 - i);
      #1;
      chk({name, "_p0"}, 32'(r_data0), 32'h0);
      chk({name, "_p1"}, 32'(r_data1), 32'h0);
      tick();
    end
  endtask

  task automatic wait_model_idle();
    int n;
    n = 0;
    while (m_age != 0 && m_age != 4 && n < 10) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", 32'(m_age != 0 && m_age != 4), 32'h0);
  endtask

  initial begin
    rst         = 1'b1;
    w_en        = 1'b0;
    w_addr      = '0;
    w_data      = '0;
    r_addr0     = '0;
    r_addr1     = '0;
    swap_start  = 1'b0;
    swap_addr_a = '0;
    swap_addr_b = '0;
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset state and full read sweep.
    chk("rst_busy", 32'(swap_busy), 32'h0);
    chk("rst_done", 32'(swap_done), 32'h0);
    sweep_zero("rst_sweep");

    // Basic swap with a dropped write in the WR_A cycle.
    write(7'd3,   8'hA5);
    write(7'd100, 8'h3C);
    swap_start  = 1'b1;
    swap_addr_a = 7'd3;
    swap_addr_b = 7'd100;
    tick();
    swap_start  = 1'b0;
    swap_addr_a = 7'd7;          // later address changes must be ignored
    swap_addr_b = 7'd8;
    chk("basic_busy1", 32'(swap_busy), 32'h1);
    chk("basic_done1", 32'(swap_done), 32'h0);
    tick();
    chk("basic_busy2", 32'(swap_busy), 32'h1);
    w_en   = 1'b1;
    w_addr = 7'd7;
    w_data = 8'hFF;
    #1;
    chk("drop_pulse", 32'(w_drop), 32'h1);
    tick();
    w_en = 1'b0;
    chk("basic_busy3", 32'(swap_busy), 32'h1);
    chk("basic_done3", 32'(swap_done), 32'h0);
    tick();
    chk("basic_busy4", 32'(swap_busy), 32'h0);
    chk("basic_done4", 32'(swap_done), 32'h1);
    tick();
    chk("basic_done5", 32'(swap_done), 32'h0);
    r_addr0 = 7'd3;
    r_addr1 = 7'd100;
    #1;
    chk("basic_mem3",   32'(r_data0), 32'h3C);
    chk("basic_mem100", 32'(r_data1), 32'hA5);
    r_addr0 = 7'd7;
    #1;
    chk("drop_mem7", 32'(r_data0), 32'h00);

    // Write and start in the same idle cycle.
    write(7'd4, 8'h22);
    w_en        = 1'b1;
    w_addr      = 7'd3;
    w_data      = 8'h11;
    swap_start  = 1'b1;
    swap_addr_a = 7'd3;
    swap_addr_b = 7'd4;
    tick();
    w_en       = 1'b0;
    swap_start = 1'b0;
    tick();
    tick();
    tick();
    chk("same_done", 32'(swap_done), 32'h1);
    r_addr0 = 7'd3;
    r_addr1 = 7'd4;
    #1;
    chk("same_mem3", 32'(r_data0), 32'h22);
    chk("same_mem4", 32'(r_data1), 32'h11);
    tick();

    // Degenerate swap followed by a back-to-back swap started in DONE.
    write(7'd1, 8'hAB);
    write(7'd2, 8'hCD);
    write(7'd5, 8'h77);
    swap_start  = 1'b1;
    swap_addr_a = 7'd5;
    swap_addr_b = 7'd5;
    tick();
    swap_start = 1'b0;
    chk("degen_busy", 32'(swap_busy), 32'h1);
    tick();
    tick();
    tick();
    chk("degen_done", 32'(swap_done), 32'h1);
    r_addr0 = 7'd5;
    #1;
    chk("degen_mem5", 32'(r_data0), 32'h77);
    swap_start  = 1'b1;
    swap_addr_a = 7'd1;
    swap_addr_b = 7'd2;
    tick();
    swap_start = 1'b0;
    chk("b2b_busy", 32'(swap_busy), 32'h1);
    tick();
    tick();
    tick();
    chk("b2b_done", 32'(swap_done), 32'h1);
    r_addr0 = 7'd1;
    r_addr1 = 7'd2;
    #1;
    chk("b2b_mem1", 32'(r_data0), 32'hCD);
    chk("b2b_mem2", 32'(r_data1), 32'hAB);
    tick();

    // Randomized traffic, small address pool half the time for collisions.
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      w_en        = 1'($urandom_range(0, 1));
      w_addr      = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      w_data      = DW'($urandom);
      swap_start  = ($urandom_range(0, 4) == 0);
      swap_addr_a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      swap_addr_b = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      r_addr0     = ($urandom_range(0, 1) != 0) ? m_a : AW'($urandom);
      r_addr1     = ($urandom_range(0, 1) != 0) ? m_b : AW'($urandom_range(0, 7));
      tick();
    end
    rst        = 1'b0;
    w_en       = 1'b0;
    swap_start = 1'b0;

    // Reset asserted in the WR_A cycle.
    wait_model_idle();
    write(7'd9, 8'h5A);
    swap_start  = 1'b1;
    swap_addr_a = 7'd10;
    swap_addr_b = 7'd9;
    tick();
    swap_start = 1'b0;
    tick();
    chk("rstmid_busy_wra", 32'(swap_busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 32'(swap_busy), 32'h0);
    chk("rstmid_done", 32'(swap_done), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_done", 32'(swap_done), 32'h0);
    end
    sweep_zero("rstmid_sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
